// File: rtl/ins_mem_loader.sv
// Purpose : packs a big-endian byte stream (16-bit word count header + data) into 32-bit
//           instruction-memory writes; holds the CPU off via Busy while a load runs.
// Latency : one write strobe per 4 accepted data bytes; 5 cycles per word minimum.
// Backpr. : ByteReady=0 in IDLE/WRITE/FIN/ERR; an offered byte is held by the source until taken.
//
// Ports:
//   CLK, Reset            rising-edge clock, synchronous active-high reset
//   Start                 1-cycle pulse starting a load (ignored while Busy)
//   ByteIn/ByteValid/     byte stream in; a transfer happens when ByteValid & ByteReady
//   ByteReady               are both high at the clock edge
//   IAddr/IDataIn/RW      InsMemory write port (RW=1 is a one-cycle write strobe)
//   Busy                  load in progress
//   Done / Err            sticky completion / rejection (count > MAX_WORDS) flags
//   WordsDone             words written in the current or last load
module ins_mem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 64
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic [31:0] IAddr,
   output logic [31:0] IDataIn,
   output logic        RW,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [15:0] WordsDone
);

   localparam logic [15:0] MaxN = 16'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      FIN,
      ERR
   } state_t;

   state_t      state;
   logic [7:0]  lenHi;
   logic [15:0] nWords;
   logic [1:0]  byteCnt;
   logic [23:0] shiftReg;   // first three bytes of the word being assembled

   wire         xfer    = ByteValid & ByteReady;
   wire  [15:0] lenFull = {lenHi, ByteIn};
   wire  [15:0] wordsNx = WordsDone + 16'd1;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= IDLE;
         lenHi     <= 8'd0;
         nWords    <= 16'd0;
         byteCnt   <= 2'd0;
         shiftReg  <= 24'd0;
         ByteReady <= 1'b0;
         IAddr     <= BASE_ADDR;
         IDataIn   <= 32'd0;
         RW        <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         WordsDone <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state     <= LEN_HI;
                  ByteReady <= 1'b1;
                  Busy      <= 1'b1;
                  Done      <= 1'b0;
                  Err       <= 1'b0;
                  WordsDone <= 16'd0;
                  IAddr     <= BASE_ADDR;
               end
            end

            LEN_HI: begin
               if (xfer) begin
                  lenHi <= ByteIn;
                  state <= LEN_LO;
               end
            end

            LEN_LO: begin
               if (xfer) begin
                  nWords  <= lenFull;
                  byteCnt <= 2'd0;
                  if (lenFull == 16'd0) begin
                     state     <= FIN;
                     ByteReady <= 1'b0;
                  end else if (lenFull > MaxN) begin
                     state     <= ERR;
                     ByteReady <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (xfer) begin
                  shiftReg <= {shiftReg[15:0], ByteIn};
                  byteCnt  <= byteCnt + 2'd1;
                  if (byteCnt == 2'd3) begin
                     // Word complete: present it on the write port for the WRITE cycle.
                     state     <= WRITE;
                     ByteReady <= 1'b0;
                     RW        <= 1'b1;
                     IDataIn   <= {shiftReg, ByteIn};
                  end
               end
            end

            WRITE: begin
               RW        <= 1'b0;
               WordsDone <= wordsNx;
               IAddr     <= IAddr + 32'd4;
               byteCnt   <= 2'd0;
               if (wordsNx == nWords) begin
                  state <= FIN;
               end else begin
                  state     <= DATA;
                  ByteReady <= 1'b1;
               end
            end

            FIN: begin
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= IDLE;
            end

            ERR: begin
               Err   <= 1'b1;
               Busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               ByteReady <= 1'b0;
               RW        <= 1'b0;
               Busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader: expected writes are queued by the stimulus, a negedge
// monitor pops and compares each RW strobe; status outputs are checked inline.
module tb_ins_mem_loader;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'd0;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic [31:0] IAddr;
   logic [31:0] IDataIn;
   logic        RW;
   logic        Busy;
   logic        Done;
   logic        Err;
   logic [15:0] WordsDone;

   ins_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .IAddr(IAddr), .IDataIn(IDataIn), .RW(RW), .Busy(Busy),
      .Done(Done), .Err(Err), .WordsDone(WordsDone)
   );

   always #5 CLK = ~CLK;

   int passCnt = 0;
   int totalCnt = 0;
   int writeCnt = 0;
   logic [63:0] expQ [$];   // {addr, data}
   logic prevRW = 1'b0;

   logic [7:0] prog [0:9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge CLK) begin
      if (RW === 1'b1) begin
         writeCnt++;
         if (prevRW) begin
            totalCnt++;
            $display("FAIL rw_pulse: got RW high two cycles in a row, expected one-cycle strobe");
         end
         if (expQ.size() == 0) begin
            totalCnt++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write", IAddr, IDataIn);
         end else begin
            logic [63:0] e;
            e = expQ.pop_front();
            chk("write_addr", IAddr, e[63:32]);
            chk("write_data", IDataIn, e[31:0]);
         end
      end
      prevRW = RW;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Offer one byte after 'gap' idle cycles; hold it until the loader takes it.
   task automatic sendByte(input logic [7:0] b, input int gap);
      int t;
      logic r;
      ByteValid = 1'b0;
      cyc(gap);
      ByteIn = b;
      ByteValid = 1'b1;
      t = 0;
      do begin
         r = ByteReady;
         cyc(1);
         t++;
      end while (!r && t < 50);
      if (!r) begin
         totalCnt++;
         $display("FAIL byte_timeout: got no transfer of %h within 50 cycles, expected accept", b);
      end
      ByteValid = 1'b0;
   endtask

   task automatic startLoad();
      Start = 1'b1;
      cyc(1);
      Start = 1'b0;
      chk("busy_after_start", {31'd0, Busy}, 32'd1);
   endtask

   task automatic waitIdle();
      int t;
      t = 0;
      while (Busy && t < 100) begin
         cyc(1);
         t++;
      end
      if (Busy) begin
         totalCnt++;
         $display("FAIL idle_timeout: got Busy=1 after 100 cycles, expected 0");
      end
   endtask

   task automatic pushProg();
      expQ.push_back({32'h0000_0000, 32'h2408_0005});
      expQ.push_back({32'h0000_0004, 32'h0008_4820});
   endtask

   initial begin
      prog = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h08, 8'h48, 8'h20};

      // Reset state
      cyc(3);
      Reset = 1'b0;
      cyc(1);
      chk("rst_iaddr", IAddr, 32'd0);
      chk("rst_idata", IDataIn, 32'd0);
      chk("rst_flags", {25'd0, RW, ByteReady, Busy, Done, Err, 2'b00}, 32'd0);
      chk("rst_words", {16'd0, WordsDone}, 32'd0);

      // 1: continuous stream
      pushProg();
      startLoad();
      for (int i = 0; i < 10; i++) sendByte(prog[i], 0);
      waitIdle();
      chk("t1_done", {31'd0, Done}, 32'd1);
      chk("t1_err", {31'd0, Err}, 32'd0);
      chk("t1_words", {16'd0, WordsDone}, 32'd2);
      chk("t1_idata_hold", IDataIn, 32'h0008_4820);
      chk("t1_queue_empty", expQ.size(), 32'd0);
      chk("t1_write_count", writeCnt, 32'd2);

      // 2: random gaps, plus a Start pulse mid-load that must be ignored
      writeCnt = 0;
      pushProg();
      startLoad();
      chk("t2_done_cleared", {31'd0, Done}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         sendByte(prog[i], $urandom_range(0, 3));
         if (i == 4) begin
            Start = 1'b1;
            cyc(1);
            Start = 1'b0;
            chk("t6_midload_busy", {31'd0, Busy}, 32'd1);
            chk("t6_midload_words", {16'd0, WordsDone}, 32'd0);
         end
      end
      waitIdle();
      chk("t2_done", {31'd0, Done}, 32'd1);
      chk("t2_words", {16'd0, WordsDone}, 32'd2);
      chk("t2_write_count", writeCnt, 32'd2);

      // 3: oversize header
      writeCnt = 0;
      startLoad();
      sendByte(8'h00, 0);
      sendByte(8'h41, 0);
      cyc(1);
      chk("t3_busy", {31'd0, Busy}, 32'd0);
      chk("t3_err", {31'd0, Err}, 32'd1);
      chk("t3_done", {31'd0, Done}, 32'd0);
      cyc(2);
      chk("t3_write_count", writeCnt, 32'd0);

      // MAX_WORDS boundary: 64 is accepted (abort by reset after header)
      startLoad();
      sendByte(8'h00, 0);
      sendByte(8'h40, 0);
      cyc(1);
      chk("max_accepted_busy", {31'd0, Busy}, 32'd1);
      chk("max_accepted_ready", {31'd0, ByteReady}, 32'd1);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;

      // 4: zero-length load
      startLoad();
      chk("t4_err_cleared", {31'd0, Err}, 32'd0);
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      cyc(1);
      chk("t4_busy", {31'd0, Busy}, 32'd0);
      chk("t4_done", {31'd0, Done}, 32'd1);
      chk("t4_words", {16'd0, WordsDone}, 32'd0);
      chk("t4_write_count", writeCnt, 32'd0);

      // 5: reset after 6 data bytes of a 2-word load
      expQ.push_back({32'h0000_0000, 32'h2408_0005});
      startLoad();
      for (int i = 0; i < 8; i++) sendByte(prog[i], 0);
      Reset = 1'b1;
      cyc(1);
      Reset = 1'b0;
      chk("t5_rw", {31'd0, RW}, 32'd0);
      chk("t5_busy", {31'd0, Busy}, 32'd0);
      chk("t5_iaddr", IAddr, 32'd0);
      chk("t5_words", {16'd0, WordsDone}, 32'd0);
      cyc(2);
      chk("t5_write_count", writeCnt, 32'd1);
      writeCnt = 0;
      pushProg();
      startLoad();
      for (int i = 0; i < 10; i++) sendByte(prog[i], 0);
      waitIdle();
      chk("t5_fresh_words", {16'd0, WordsDone}, 32'd2);
      chk("t5_fresh_write_count", writeCnt, 32'd2);

      // 6: Start together with Reset -- Reset wins
      Reset = 1'b1;
      Start = 1'b1;
      cyc(1);
      Reset = 1'b0;
      Start = 1'b0;
      cyc(1);
      chk("t6_rst_start_busy", {31'd0, Busy}, 32'd0);
      chk("t6_rst_start_ready", {31'd0, ByteReady}, 32'd0);
      chk("t6_rst_start_done", {31'd0, Done}, 32'd0);

      chk("final_queue_empty", expQ.size(), 32'd0);
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
